// File: rtl/step_phase_sequencer_pkg.sv
// Shared types and constants for the stepper phase sequencer:
// FSM state encoding, coil width and the 8-entry unipolar phase table.
package step_phase_sequencer_pkg;

  localparam int COIL_W = 4;
  localparam int NUM_PHASES = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    SETTLE = 2'd2
  } seqState_t;

  // Half-step walk; odd indices are the two-coil (full-step) entries.
  localparam logic [NUM_PHASES-1:0][COIL_W-1:0] PHASE_TABLE = {
    4'b1001, 4'b0001, 4'b0011, 4'b0010,
    4'b0110, 4'b0100, 4'b1100, 4'b1000
  };

  // Index stride for a taken step: full-step from an even index snaps by
  // one onto a two-coil entry, otherwise full-step strides by two.
  function automatic logic [2:0] phaseStride(input logic halfStep, input logic [2:0] idx);
    return (!halfStep && idx[0]) ? 3'd2 : 3'd1;
  endfunction

endpackage

// File: rtl/step_phase_sequencer_step_edge_detect.sv
// Registered rising-edge detector: one-cycle pulse on a 0->1 transition.
module step_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic sigQ;

  // Sample the input once per cycle; pulse is combinational off the sample.
  always_ff @(posedge clk) begin
    if (rst) sigQ <= 1'b0;
    else     sigQ <= sig;
  end

  assign rise = sig & ~sigQ;

endmodule

// File: rtl/step_phase_sequencer.sv
// Step/direction to unipolar coil phase sequencer with direction-change
// settle window and signed half-step position count.
// Optional: STEP_PHASE_IDLE_DEENERGIZE_EN drops coil drive after
// IDLE_TIMEOUT cycles in RUN without a step; the next step restores it.
module step_phase_sequencer
  import step_phase_sequencer_pkg::*;
#(
  parameter int POS_W        = 16,
  parameter int DIR_SETTLE   = 8,
  parameter int IDLE_TIMEOUT = 1000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    step_in,
  input  logic                    dir,
  input  logic                    half_step,
  input  logic                    enable,
  input  logic                    clr_flag,
  output logic [COIL_W-1:0]       coil,
  output logic signed [POS_W-1:0] position,
  output logic                    step_dropped,
  output logic                    settling
);

  localparam logic [7:0] SETTLE_LOAD = 8'(DIR_SETTLE - 1);

  seqState_t               state;
  logic [7:0]              settleCnt;
  logic                    dirQ;
  logic [2:0]              phaseIdx;
  logic                    stepEdge;
  logic                    dirChange;
  logic                    stepTaken;
  logic [2:0]              stride;
  logic [2:0]              idxNext;
  logic [POS_W-1:0]        posStride;
  logic signed [POS_W-1:0] posNext;
  logic                    coilBlank;

  step_edge_detect u_stepEdge (
    .clk  (clk),
    .rst  (rst),
    .sig  (step_in),
    .rise (stepEdge)
  );

  assign dirChange = dir ^ dirQ;
  // A step coinciding with a direction change is refused; the settle
  // window starts instead.
  assign stepTaken = (state == RUN) && enable && stepEdge && !dirChange;
  assign stride    = phaseStride(half_step, phaseIdx);
  assign posStride = {{(POS_W-3){1'b0}}, stride};

  // Next phase index and position; both move by the same signed stride.
  always_comb begin
    idxNext = phaseIdx;
    posNext = position;
    if (stepTaken) begin
      idxNext = dir ? phaseIdx + stride : phaseIdx - stride;
      posNext = dir ? position + posStride : position - posStride;
    end
  end

`ifdef STEP_PHASE_IDLE_DEENERGIZE_EN
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(IDLE_TIMEOUT);

  logic [IDLE_W-1:0] idleCnt;
  logic [IDLE_W-1:0] idleNext;

  // Idle count runs only in RUN, saturates at the limit, clears on a step.
  always_comb begin
    idleNext = '0;
    if (state == RUN && !stepTaken)
      idleNext = (idleCnt >= IDLE_LIMIT) ? idleCnt : idleCnt + 1'b1;
  end

  // Idle counter register.
  always_ff @(posedge clk) begin
    if (rst) idleCnt <= '0;
    else     idleCnt <= idleNext;
  end

  assign coilBlank = (idleNext >= IDLE_LIMIT);
`else
  assign coilBlank = 1'b0;
`endif

  // Control FSM: enable gating, settle window after a direction change.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      settleCnt <= '0;
      settling  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) state <= RUN;
        end
        RUN: begin
          if (!enable) begin
            state <= IDLE;
          end else if (dirChange) begin
            state     <= SETTLE;
            settleCnt <= SETTLE_LOAD;
            settling  <= 1'b1;
          end
        end
        SETTLE: begin
          if (!enable) begin
            state    <= IDLE;
            settling <= 1'b0;
          end else if (dirChange) begin
            settleCnt <= SETTLE_LOAD;
          end else if (settleCnt == '0) begin
            state    <= RUN;
            settling <= 1'b0;
          end else begin
            settleCnt <= settleCnt - 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          settling <= 1'b0;
        end
      endcase
    end
  end

  // Phase, position, coil drive and the sticky drop flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      dirQ         <= 1'b0;
      phaseIdx     <= '0;
      position     <= '0;
      coil         <= '0;
      step_dropped <= 1'b0;
    end else begin
      dirQ     <= dir;
      phaseIdx <= idxNext;
      position <= posNext;
      coil     <= (enable && !coilBlank) ? PHASE_TABLE[idxNext] : '0;
      if (stepEdge && !stepTaken) step_dropped <= 1'b1;
      else if (clr_flag)          step_dropped <= 1'b0;
    end
  end

endmodule
